// File: rtl/titan_ifid_queue.sv
// -----------------------------------------------------------------------------
// titan_ifid_queue
//   IF->ID fetch queue holding up to DEPTH fetched instructions together with
//   their PC and fetch exception/trap information. Fetch and decode are
//   decoupled by a valid/ready handshake. ID sees a NOP bubble whenever the
//   queue is empty, and a flush from ID drops every entry.
//
// Parameters
//   XLEN   width of PC, instruction and exception data
//   EXC_W  width of the exception code field
//   DEPTH  number of entries (power of two, >= 2)
//   NOP    instruction presented to ID while the queue is empty
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   id_flush        synchronous flush, discards all entries
//   id_stall        ID cannot consume the head entry this cycle
//   if_valid/ready  fetch-side handshake (ready = not full)
//   if_pc, if_inst, if_exception_i, if_trap_valid, if_exc_data
//                   fetched entry fields
//   id_valid        head entry valid (= not empty)
//   id_pc, id_inst, if_exception_o, id_trap_valid, id_exc_data
//                   head entry fields, bubble values while empty
//   id_count        occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module titan_ifid_queue #(
  parameter int unsigned     XLEN  = 32,
  parameter int unsigned     EXC_W = 4,
  parameter int unsigned     DEPTH = 2,
  parameter logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0033),
  localparam int unsigned    CW    = $clog2(DEPTH + 1),
  localparam int unsigned    PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_flush,
  input  logic             id_stall,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [XLEN-1:0]  if_inst,
  input  logic [EXC_W-1:0] if_exception_i,
  input  logic             if_trap_valid,
  input  logic [XLEN-1:0]  if_exc_data,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_inst,
  output logic [EXC_W-1:0] if_exception_o,
  output logic             id_trap_valid,
  output logic [XLEN-1:0]  id_exc_data,
  output logic [CW-1:0]    id_count
);

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  inst;
    logic [EXC_W-1:0] exc;
    logic             trap;
    logic [XLEN-1:0]  data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic            push;
  logic            pop;
  entry_t          wr_entry;
  entry_t          head;

  // Handshake status comes only from registered occupancy, so if_ready has no
  // combinational path from id_stall and a full queue never accepts a push,
  // even when a pop happens in the same cycle.
  assign if_ready = (count_q != CW'(DEPTH));
  assign id_valid = (count_q != '0);
  assign id_count = count_q;

  assign push = if_valid & if_ready;
  assign pop  = id_valid & ~id_stall;

  assign wr_entry = '{pc:   if_pc,
                      inst: if_inst,
                      exc:  if_exception_i,
                      trap: if_trap_valid,
                      data: if_exc_data};

  // Next-state logic; flush overrides any push/pop in the same cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (id_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the empty check below
  // masks stale contents, so resetting it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push && !id_flush) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head = mem_q[rd_ptr_q];

  // Head presentation: bubble values whenever the queue is empty.
  always_comb begin
    id_pc          = '0;
    id_inst        = NOP;
    if_exception_o = '0;
    id_trap_valid  = 1'b0;
    id_exc_data    = '0;
    if (id_valid) begin
      id_pc          = head.pc;
      id_inst        = head.inst;
      if_exception_o = head.exc;
      id_trap_valid  = head.trap;
      id_exc_data    = head.data;
    end
  end

endmodule
